// File: rtl/spr_case_detect_stream.sv
// spr_case_detect_stream
//   Multi-channel special-case / edge detector for the SPR datapath. Builds a
//   prev/curr/next window per channel from the raw pixel stream and emits
//   is_original / is_edge flags with the syncs delayed to match. It also counts
//   edge pixels per channel over each frame.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   i_hs, i_vs    input line / frame active; a pixel is accepted when both are high
//   i_data        CH samples of DW bits, channel 0 in the LSBs
//   spr_thr_edge  edge threshold, captured when i_vs rises
//   pad_mode      0 = replicate the edge pixel, 1 = zero pad; captured when i_vs rises
//   o_hs, o_vs    i_hs / i_vs delayed by 2 cycles
//   o_data        the curr sample, aligned with the flags
//   is_original   per-channel original flag
//   is_edge       per channel {edge2,edge3,edge4,edge5}; channel c at [4c+3:4c]
//   o_edge_cnt    edge-pixel count per channel for the last completed frame
//   o_cnt_valid   one-cycle pulse when o_edge_cnt updates
module spr_case_detect_stream #(
  parameter int DW    = 12,
  parameter int CH    = 3,
  parameter int SHIFT = 4,
  parameter int CNT_W = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_hs,
  input  logic                i_vs,
  input  logic [CH*DW-1:0]    i_data,
  input  logic [DW-1:0]       spr_thr_edge,
  input  logic                pad_mode,
  output logic                o_hs,
  output logic                o_vs,
  output logic [CH*DW-1:0]    o_data,
  output logic [CH-1:0]       is_original,
  output logic [4*CH-1:0]     is_edge,
  output logic [CH*CNT_W-1:0] o_edge_cnt,
  output logic                o_cnt_valid
);

  logic de;
  logic de_q;          // curr_q holds a pixel that still has to be emitted
  logic de_q2;         // prev_q holds a pixel from the same line as curr_q
  logic hs_d1, vs_d1;
  logic vs_prev;       // frame-start detector for the shadow capture
  logic o_vs_q;
  logic [DW-1:0]    thr_sh;
  logic             pad_sh;
  logic [CH*DW-1:0] curr_q, prev_q;
  logic [4*CH-1:0]  edge_c;
  logic [CH-1:0]    orig_c;
  logic [DW:0]      thr_x;
  logic             frame_end;
  logic [CNT_W-1:0] run_q [CH];

  assign de        = i_hs & i_vs;
  assign thr_x     = {1'b0, thr_sh};
  assign frame_end = o_vs_q & ~o_vs;

  // Sync delay line, window shift and line-position tracking.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_d1  <= 1'b0;
      vs_d1  <= 1'b0;
      o_hs   <= 1'b0;
      o_vs   <= 1'b0;
      o_vs_q <= 1'b0;
      de_q   <= 1'b0;
      de_q2  <= 1'b0;
      curr_q <= '0;
      prev_q <= '0;
    end else begin
      hs_d1  <= i_hs;
      vs_d1  <= i_vs;
      o_hs   <= hs_d1;
      o_vs   <= vs_d1;
      o_vs_q <= o_vs;
      de_q   <= de;
      de_q2  <= de_q;
      if (de) begin
        curr_q <= i_data;
        prev_q <= curr_q;
      end
    end
  end

  // Shadow capture on a real 0->1 of i_vs. vs_prev comes out of reset high so
  // a frame still active across a reset does not look like a new frame start
  // and keeps running with the cleared shadows.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev <= 1'b1;
      thr_sh  <= '0;
      pad_sh  <= 1'b0;
    end else begin
      vs_prev <= i_vs;
      if (i_vs && !vs_prev) begin
        thr_sh <= spr_thr_edge;
        pad_sh <= pad_mode;
      end
    end
  end

  // Per-channel window evaluation. It runs in the cycle after a pixel is
  // accepted. At that point next is either the pixel arriving now or, if de
  // has dropped, the line-end pad. When de_q2 is low, curr is the first pixel
  // of its line and prev is the line-start pad.
  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [DW-1:0] c, p, n;
    logic [DW:0]   cp, cn, mag_p, mag_n, a, b;
    logic          neg;

    assign c = curr_q[g*DW +: DW];
    assign p = de_q2 ? prev_q[g*DW +: DW] : (pad_sh ? '0 : c);
    assign n = de    ? i_data[g*DW +: DW] : (pad_sh ? '0 : c);

    assign cp    = {1'b0, c} - {1'b0, p};
    assign cn    = {1'b0, c} - {1'b0, n};
    assign neg   = cp[DW];
    assign mag_p = cp[DW] ? -cp : cp;
    assign mag_n = cn[DW] ? -cn : cn;
    assign a     = mag_p >> SHIFT;
    assign b     = mag_n >> SHIFT;

    assign edge_c[4*g +: 4] = {
      !neg && (a >= thr_x) && (b >= thr_x),
      !neg && (a >= thr_x) && (b <  thr_x),
       neg && (a >= thr_x) && (b <= thr_x),
       neg && (a >= thr_x) && (b >  thr_x)
    };
    assign orig_c[g] = (p == '0) ^ (c == '0);
  end

  // Output stage. A pixel is emitted exactly when de_q is high, and this
  // lines up with o_hs & o_vs one cycle later. Outside active video the
  // outputs are therefore held at zero.
  always_ff @(posedge clk) begin
    if (rst || !de_q) begin
      o_data      <= '0;
      is_edge     <= '0;
      is_original <= '0;
    end else begin
      o_data      <= curr_q;
      is_edge     <= edge_c;
      is_original <= orig_c;
    end
  end

  // Frame statistics. The count is taken from the registered outputs, which
  // are zero whenever o_vs is low. A snapshot and an increment therefore
  // never fall in the same cycle.
  // NOTE: run_q is a handful of counters rather than a RAM, so it is reset
  // like any other register; a true memory would be left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q       <= '{default: '0};
      o_edge_cnt  <= '0;
      o_cnt_valid <= 1'b0;
    end else begin
      o_cnt_valid <= frame_end;
      for (int i = 0; i < CH; i++) begin
        if (frame_end) begin
          o_edge_cnt[i*CNT_W +: CNT_W] <= run_q[i];
          run_q[i]                     <= '0;
        end else if ((|is_edge[4*i +: 4]) && (run_q[i] != '1)) begin
          run_q[i] <= run_q[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spr_case_detect_stream.sv
// Self-checking bench for spr_case_detect_stream. The stimulus pushes the
// expected flags for every pixel into a scoreboard queue. A negedge monitor
// pops and compares them whenever o_hs & o_vs is high.
module tb_spr_case_detect_stream;
  localparam int DW    = 12;
  localparam int CH    = 3;
  localparam int SHIFT = 4;
  localparam int CNT_W = 4;
  localparam int PW    = CH * DW;

  typedef struct packed {
    logic [PW-1:0]   data;
    logic [CH-1:0]   orig;
    logic [4*CH-1:0] edges;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_hs, i_vs;
  logic [PW-1:0]      i_data;
  logic [DW-1:0]      spr_thr_edge;
  logic               pad_mode;
  logic               o_hs, o_vs;
  logic [PW-1:0]      o_data;
  logic [CH-1:0]      is_original;
  logic [4*CH-1:0]    is_edge;
  logic [CH*CNT_W-1:0] o_edge_cnt;
  logic               o_cnt_valid;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t e;
  logic [PW-1:0] line_buf[$];
  int   model_thr;
  int   model_pad;
  bit   mon_en = 1'b0;
  bit   hs_chk = 1'b0;
  logic [1:0] hs_hist = 2'b00;

  spr_case_detect_stream #(.DW(DW), .CH(CH), .SHIFT(SHIFT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i_hs(i_hs), .i_vs(i_vs), .i_data(i_data),
    .spr_thr_edge(spr_thr_edge), .pad_mode(pad_mode),
    .o_hs(o_hs), .o_vs(o_vs), .o_data(o_data), .is_original(is_original),
    .is_edge(is_edge), .o_edge_cnt(o_edge_cnt), .o_cnt_valid(o_cnt_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) hs_hist <= {hs_hist[0], i_hs};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] ref_edge(input int p, input int c, input int n, input int thr);
    int  dp, dn, a, b;
    bit  neg;
    dp  = c - p;
    dn  = c - n;
    neg = dp < 0;
    a   = (dp < 0 ? -dp : dp) >> SHIFT;
    b   = (dn < 0 ? -dn : dn) >> SHIFT;
    return {!neg && a >= thr && b >= thr, !neg && a >= thr && b < thr,
             neg && a >= thr && b <= thr,  neg && a >= thr && b > thr};
  endfunction

  function automatic logic [PW-1:0] pix(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                                        input logic [DW-1:0] c2);
    return {c2, c1, c0};
  endfunction

  // Scoreboard monitor: compare the pixel flags, check idle zeros and the
  // sync delay.
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_hs && o_vs) begin
        check("sb_pending", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("pix_data", o_data, e.data);
          check("pix_orig", is_original, e.orig);
          check("pix_edge", is_edge, e.edges);
        end
      end else begin
        check("idle_zero", {o_data, is_original, is_edge}, '0);
      end
      if (hs_chk) check("o_hs_delay2", o_hs, hs_hist[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int thr, input int pad);
    spr_thr_edge = thr[DW-1:0];
    pad_mode     = pad[0];
    model_thr    = thr;
    model_pad    = pad;
    i_vs         = 1'b1;
    tick();
    // Mid-frame changes must be ignored until the next frame.
    spr_thr_edge = ~thr[DW-1:0];
    pad_mode     = ~pad[0];
    tick();
  endtask

  // Push the expected results for line_buf, then drive it followed by blanking.
  task automatic drive_line(input int blank);
    exp_t          ent;
    logic [PW-1:0] cur, nb;
    int            c, p, n, last;
    last = line_buf.size() - 1;
    for (int i = 0; i <= last; i++) begin
      cur       = line_buf[i];
      ent.data  = cur;
      ent.orig  = '0;
      ent.edges = '0;
      for (int ch = 0; ch < CH; ch++) begin
        c = int'(cur[ch*DW +: DW]);
        if (i == 0) p = model_pad ? 0 : c;
        else begin nb = line_buf[i-1]; p = int'(nb[ch*DW +: DW]); end
        if (i == last) n = model_pad ? 0 : c;
        else begin nb = line_buf[i+1]; n = int'(nb[ch*DW +: DW]); end
        ent.orig[ch]        = (p == 0) ^ (c == 0);
        ent.edges[4*ch +: 4] = ref_edge(p, c, n, model_thr);
      end
      exp_q.push_back(ent);
    end
    for (int i = 0; i <= last; i++) begin
      i_hs   = 1'b1;
      i_data = line_buf[i];
      tick();
    end
    i_hs   = 1'b0;
    i_data = '0;
    repeat (blank) tick();
  endtask

  task automatic end_frame(input bit do_chk, input logic [CH*CNT_W-1:0] exp_cnt);
    i_vs = 1'b0;
    i_hs = 1'b0;
    if (do_chk) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check($sformatf("cnt_valid_t%0d", k), o_cnt_valid, k == 3);
        if (k == 3) check("edge_cnt", o_edge_cnt, exp_cnt);
      end
      tick();
    end else begin
      repeat (5) tick();
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; i_hs = 1'b0; i_vs = 1'b0; i_data = '0;
    spr_thr_edge = '0; pad_mode = 1'b0;
    model_thr = 0; model_pad = 0;
    repeat (2) tick();
    @(negedge clk);
    check("reset_sync", {o_hs, o_vs, o_cnt_valid}, 3'b000);
    check("reset_out", {o_data, is_original, is_edge}, '0);
    check("reset_cnt", o_edge_cnt, '0);
    rst = 1'b0;
    tick();
    mon_en = 1'b1;
    hs_chk = 1'b1;

    // Replicate padding, thr=2: 0x000,0x100,0x000 on channel 0.
    start_frame(2, 0);
    line_buf = '{pix(12'h000, 12'h000, 12'h000), pix(12'h100, 12'h000, 12'h000),
                 pix(12'h000, 12'h000, 12'h000)};
    drive_line(2);
    end_frame(0, '0);

    // Same line with zero padding.
    start_frame(2, 1);
    drive_line(2);
    end_frame(0, '0);

    // Single-pixel lines, back to back, zero pad then replicate.
    start_frame(1, 1);
    line_buf = '{pix(12'h050, 12'h050, 12'h050)};
    drive_line(1);
    drive_line(3);
    end_frame(0, '0);
    start_frame(1, 0);
    drive_line(1);
    drive_line(3);
    end_frame(0, '0);

    // Two lines with 1-cycle blanking: no window may span the boundary.
    start_frame(3, 1);
    line_buf = '{pix(12'h123, 12'h800, 12'h010), pix(12'hfff, 12'h000, 12'h020),
                 pix(12'h000, 12'h7ff, 12'h300)};
    drive_line(1);
    line_buf = '{pix(12'h400, 12'h000, 12'habc), pix(12'h050, 12'h900, 12'h001)};
    drive_line(3);
    end_frame(0, '0);

    // Statistics: 20 edge pixels on ch1 (saturates at 15), 3 on ch2.
    start_frame(2, 0);
    line_buf.delete();
    for (int i = 0; i < 11; i++)
      line_buf.push_back(pix(12'h000, (i % 2) ? 12'h100 : 12'h000, (i == 1) ? 12'h100 : 12'h000));
    drive_line(1);
    line_buf.delete();
    for (int i = 0; i < 11; i++)
      line_buf.push_back(pix(12'h000, (i % 2) ? 12'h100 : 12'h000, (i == 10) ? 12'h100 : 12'h000));
    drive_line(2);
    end_frame(1, {4'd3, 4'd15, 4'd0});

    // The next frame counts from zero: 2 edge pixels on ch1.
    start_frame(2, 0);
    line_buf = '{pix(12'h000, 12'h000, 12'h000), pix(12'h000, 12'h100, 12'h000),
                 pix(12'h000, 12'h000, 12'h000)};
    drive_line(2);
    end_frame(1, {4'd0, 4'd2, 4'd0});

    // Reset mid-line: the line is dropped, and the frame carries on with thr=0.
    start_frame(5, 1);
    mon_en = 1'b0;
    hs_chk = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_hs   = 1'b1;
      i_data = pix(12'h100 * i[11:0], 12'h300, 12'h000);
      tick();
    end
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rst_mid_sync", {o_hs, o_vs}, 2'b00);
    check("rst_mid_out", {o_data, is_original, is_edge}, '0);
    i_hs = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_out%0d", k), {o_hs, o_data, is_original, is_edge}, '0);
      check($sformatf("post_rst_cv%0d", k), o_cnt_valid, 1'b0);
    end
    tick();
    model_thr    = 0;
    model_pad    = 0;
    spr_thr_edge = 12'h7ff;
    pad_mode     = 1'b1;
    mon_en       = 1'b1;
    line_buf = '{pix(12'h010, 12'h200, 12'h000), pix(12'h020, 12'h100, 12'h000),
                 pix(12'h000, 12'h100, 12'h005)};
    drive_line(2);
    end_frame(0, '0);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spr_case_detect_stream.md
# spr_case_detect_stream

Parametrised, multi-channel successor to the single-channel special-case/edge detector in the SPR datapath. It accepts a raw pixel stream qualified by `i_hs`/`i_vs`, builds the prev/curr/next window internally per channel, and emits aligned `is_original`/`is_edge` flags with delayed syncs. Line boundaries are handled with a selectable padding mode. Per-frame edge statistics are accumulated for firmware threshold tuning. It sits between the input sync stage and the SPR filter, replacing externally supplied tap registers.

## Interface
- `DW`, 12, channel sample width
- `CH`, 3, number of channels (R,G,B order: channel 0 = LSBs)
- `SHIFT`, 4, right shift applied to differences before threshold compare
- `CNT_W`, 20, width of per-channel frame edge counters
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `i_hs`  in  1  line active (high = active pixels)
- `i_vs`  in  1  frame active
- `i_data`  in  CH*DW  pixel samples, valid when `i_hs & i_vs`
- `spr_thr_edge`  in  DW  edge threshold (shadowed per frame)
- `pad_mode`  in  1  0 = replicate edge pixel, 1 = zero pad (shadowed per frame)
- `o_hs`, `o_vs`  out  1  syncs delayed by 2 cycles
- `o_data`  out  CH*DW  `curr` samples aligned with flags
- `is_original`  out  CH  per-channel original flag
- `is_edge`  out  4*CH  per channel {edge2,edge3,edge4,edge5}, channel c at [4c+3:4c]
- `o_edge_cnt`  out  CH*CNT_W  last completed frame's edge-pixel count per channel
- `o_cnt_valid`  out  1  one-cycle pulse when `o_edge_cnt` updates

## Operation
- `de = i_hs & i_vs`. A pixel is accepted every cycle `de` is high; no backpressure.
- Shadow regs: `spr_thr_edge`/`pad_mode` are captured on the cycle `i_vs` rises (0→1). Reset value is 0 for both.
- Window per channel: `next` = incoming pixel, `curr` = previous accepted pixel, `prev` = one before.
- First pixel of a line has `prev` = curr (replicate) or 0 (zero pad).
- Last pixel of a line is flushed on the first cycle `de` is low after being high. Its `next` = curr (replicate) or 0 (zero pad).
- Single-pixel line: both pads are applied.
- Windows never span lines.
- `vs` falling with `hs` still high is a line end: the flush occurs.
- Arithmetic, per channel, at DW+1 bits:
  - `cp = curr - prev`, `cn = curr - next`; `neg = cp[DW]`.
  - `|x|` = two's-complement magnitude.
  - `A = |cp|>>SHIFT`, `B = |cn|>>SHIFT`, both compared unsigned against `thr`.
- Edge flags:
  - edge2 = !neg & A>=thr & B>=thr
  - edge3 = !neg & A>=thr & B<thr
  - edge4 = neg & A>=thr & B<=thr
  - edge5 = neg & A>=thr & B>thr
- `cp == 0` is treated as non-negative.
- `is_original = (prev==0) ^ (curr==0)`.
- When `o_hs & o_vs` is low, `is_original`, `is_edge` and `o_data` are 0.
- Statistics, per channel:
  - The running count increments on each output pixel with any edge bit set, saturating at 2^CNT_W−1.
  - On the cycle after `o_vs` falls, the running count is copied to `o_edge_cnt`, the running count is cleared, and `o_cnt_valid` pulses.

## Timing
- Fixed latency of 2 for every pixel, including the flushed last pixel: a pixel accepted in cycle t has its flags and `o_data` valid in cycle t+2.
- `o_hs`/`o_vs` equal `i_hs`/`i_vs` delayed 2 cycles.
- Minimum horizontal blanking is 1 cycle (the flush cycle). Back-to-back lines with 1-cycle blanking must work.
- `o_cnt_valid` is asserted in cycle t+3, where t is the cycle `i_vs` falls.
- Reset (any time, including mid-line or mid-frame):
  - All outputs, window registers, pad/first-pixel state, shadows and counters go to 0 on the next edge.
  - `o_cnt_valid` is not pulsed.
  - A line in progress is dropped: no flush.
- Threshold changes mid-frame have no effect until the next `i_vs` rise.

## Test plan
- CH=3, DW=12, thr=2, replicate. Line 0x000,0x100,0x000 on channel 0 → flags at t+2..t+4:
  - pixel0 `is_edge`=0000, `is_original`=0
  - pixel1 1000, `is_original`=1
  - pixel2 0010, `is_original`=1
- Same line with `pad_mode`=1 → pixel2 `next`=0, cn=0 → 0010 unchanged; pixel0 `prev`=0, cp=0 → 0000.
- Single-pixel lines, value 0x050, thr=1:
  - `pad_mode`=1 → `is_edge`=1000, `is_original`=1
  - `pad_mode`=0 → 0000, `is_original`=0
  - Output one cycle after the hs fall is also checked.
- Two lines with 1-cycle blanking, values differing per channel → no cross-line window. Check the last/first pixels against a padding model. Check `o_hs` delay = 2.
- CNT_W=4, frame with 20 edge pixels on channel 1 and 3 on channel 2 → at vs fall +3 cycles, `o_cnt_valid`=1 and counts ch1=15 (saturated), ch2=3. Next frame's counters start from 0.
- Assert `rst` mid-line, then release → all outputs 0, no flush, no `o_cnt_valid`. The following frame uses thr=0 until the next `i_vs` rise.
